// File: rtl/hazard_pkg.sv
// Shared encodings for the pipeline hazard/forwarding controller.
package hazard_pkg;

  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_W  = 2'b01,
    FWD_M  = 2'b10
  } fwd_sel_e;

  localparam int REG_ZERO = 0;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/hazard_ctrl_md_busy_ctr.sv
// Mult/div busy countdown: loads the unit latency on issue, counts down to idle.
module md_busy_ctr
  import hazard_pkg::*;
#(
  parameter int MUL_LAT = 5,
  parameter int DIV_LAT = 10
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic is_div,
  output logic busy
);

  localparam int CNT_W = $clog2(max_int(MUL_LAT, DIV_LAT) + 1);
  localparam logic [CNT_W-1:0] MUL_V = CNT_W'(MUL_LAT);
  localparam logic [CNT_W-1:0] DIV_V = CNT_W'(DIV_LAT);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // A start while already busy simply reloads; the latest issue wins.
  always_comb begin
    cnt_d = cnt_q;
    if (start) begin
      cnt_d = is_div ? DIV_V : MUL_V;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign busy = (cnt_q != '0);

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard detection and operand forwarding for the 5-stage pipeline; only state is the MDU countdown.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_AW  = 5,
  parameter int MUL_LAT = 5,
  parameter int DIV_LAT = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_AW-1:0] rs_D,
  input  logic [REG_AW-1:0] rt_D,
  input  logic              use_rs_D,
  input  logic              use_rt_D,
  input  logic              branch_D,
  input  logic              jr_D,
  input  logic              md_use_D,
  input  logic [REG_AW-1:0] rs_E,
  input  logic [REG_AW-1:0] rt_E,
  input  logic [REG_AW-1:0] writereg_E,
  input  logic              regwrite_E,
  input  logic              memtoreg_E,
  input  logic              md_start_E,
  input  logic              md_div_E,
  input  logic [REG_AW-1:0] writereg_M,
  input  logic              regwrite_M,
  input  logic              memtoreg_M,
  input  logic [REG_AW-1:0] writereg_W,
  input  logic              regwrite_W,
  output logic [1:0]        fwd_AE,
  output logic [1:0]        fwd_BE,
  output logic              fwd_AD,
  output logic              fwd_BD,
  output logic              stall_F,
  output logic              stall_D,
  output logic              flush_E,
  output logic              md_busy
);

  localparam logic [REG_AW-1:0] ZERO_R = REG_AW'(REG_ZERO);

  // $0 is hardwired, so a write to it never creates a dependency.
  function automatic logic dep(input logic [REG_AW-1:0] dst, input logic [REG_AW-1:0] src);
    return (dst != ZERO_R) && (dst == src);
  endfunction

  logic m_rs_hit, m_rt_hit, w_rs_hit, w_rt_hit;
  logic e_rsd, e_rtd, m_rsd, m_rtd;
  logic match_e, match_m, br_match_e, br_match_m;
  logic lw_stall, br_stall, md_stall, stall;

  md_busy_ctr #(
    .MUL_LAT(MUL_LAT),
    .DIV_LAT(DIV_LAT)
  ) u_md_busy_ctr (
    .clk   (clk),
    .rst_n (rst_n),
    .start (md_start_E),
    .is_div(md_div_E),
    .busy  (md_busy)
  );

  always_comb begin
    m_rs_hit = regwrite_M && dep(writereg_M, rs_E);
    m_rt_hit = regwrite_M && dep(writereg_M, rt_E);
    w_rs_hit = regwrite_W && dep(writereg_W, rs_E);
    w_rt_hit = regwrite_W && dep(writereg_W, rt_E);

    fwd_AE = FWD_RF;
    if (m_rs_hit) fwd_AE = FWD_M;
    else if (w_rs_hit) fwd_AE = FWD_W;

    fwd_BE = FWD_RF;
    if (m_rt_hit) fwd_BE = FWD_M;
    else if (w_rt_hit) fwd_BE = FWD_W;
  end

  always_comb begin
    e_rsd = use_rs_D && dep(writereg_E, rs_D);
    e_rtd = use_rt_D && dep(writereg_E, rt_D);
    m_rsd = use_rs_D && dep(writereg_M, rs_D);
    m_rtd = use_rt_D && dep(writereg_M, rt_D);

    match_e = e_rsd || e_rtd;
    match_m = m_rsd || m_rtd;

    // Branches compare both operands in D; jr only consumes rs.
    br_match_e = (branch_D && match_e) || (jr_D && e_rsd);
    br_match_m = (branch_D && match_m) || (jr_D && m_rsd);

    fwd_AD = (branch_D || jr_D) && regwrite_M && !memtoreg_M && m_rsd;
    fwd_BD = branch_D && regwrite_M && !memtoreg_M && m_rtd;

    lw_stall = memtoreg_E && regwrite_E && match_e;
    br_stall = (regwrite_E && br_match_e) || (memtoreg_M && br_match_m);
    md_stall = md_use_D && (md_busy || md_start_E);

    stall   = lw_stall || br_stall || md_stall;
    stall_F = stall;
    stall_D = stall;
    flush_E = stall;
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: behavioural model checked every cycle plus literal directed scenarios.
module tb_hazard_ctrl;

  localparam int AW = 5;
  localparam int MUL = 5;
  localparam int DIV = 10;

  logic clk = 1'b0;
  logic rst_n;
  logic [AW-1:0] rs_D, rt_D, rs_E, rt_E, writereg_E, writereg_M, writereg_W;
  logic use_rs_D, use_rt_D, branch_D, jr_D, md_use_D;
  logic regwrite_E, memtoreg_E, md_start_E, md_div_E;
  logic regwrite_M, memtoreg_M, regwrite_W;
  logic [1:0] fwd_AE, fwd_BE;
  logic fwd_AD, fwd_BD, stall_F, stall_D, flush_E, md_busy;

  int n_tests = 0;
  int n_fail = 0;
  int cyc = 0;
  int busy_until = -1;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  hazard_ctrl #(.REG_AW(AW), .MUL_LAT(MUL), .DIV_LAT(DIV)) dut (
    .clk(clk), .rst_n(rst_n),
    .rs_D(rs_D), .rt_D(rt_D), .use_rs_D(use_rs_D), .use_rt_D(use_rt_D),
    .branch_D(branch_D), .jr_D(jr_D), .md_use_D(md_use_D),
    .rs_E(rs_E), .rt_E(rt_E), .writereg_E(writereg_E), .regwrite_E(regwrite_E),
    .memtoreg_E(memtoreg_E), .md_start_E(md_start_E), .md_div_E(md_div_E),
    .writereg_M(writereg_M), .regwrite_M(regwrite_M), .memtoreg_M(memtoreg_M),
    .writereg_W(writereg_W), .regwrite_W(regwrite_W),
    .fwd_AE(fwd_AE), .fwd_BE(fwd_BE), .fwd_AD(fwd_AD), .fwd_BD(fwd_BD),
    .stall_F(stall_F), .stall_D(stall_D), .flush_E(flush_E), .md_busy(md_busy)
  );

  // MDU model: an issue during cycle t keeps the unit busy through cycle t+LAT.
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy_until <= -1;
    else if (md_start_E) busy_until <= cyc + (md_div_E ? DIV : MUL);
  end

  task automatic cmp(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic bit hit(input int dst, input int src, input bit wen);
    return wen && dst != 0 && dst == src;
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      int e_ae, e_be;
      bit e_ad, e_bd, e_st, m_busy;
      bit eh_rs, eh_rt, mh_rs, mh_rt, lw, br, md;
      m_busy = (cyc <= busy_until);
      e_ae = hit(writereg_M, rs_E, regwrite_M) ? 2 : hit(writereg_W, rs_E, regwrite_W) ? 1 : 0;
      e_be = hit(writereg_M, rt_E, regwrite_M) ? 2 : hit(writereg_W, rt_E, regwrite_W) ? 1 : 0;
      eh_rs = use_rs_D && hit(writereg_E, rs_D, 1'b1);
      eh_rt = use_rt_D && hit(writereg_E, rt_D, 1'b1);
      mh_rs = use_rs_D && hit(writereg_M, rs_D, 1'b1);
      mh_rt = use_rt_D && hit(writereg_M, rt_D, 1'b1);
      e_ad = (branch_D || jr_D) && regwrite_M && !memtoreg_M && mh_rs;
      e_bd = branch_D && regwrite_M && !memtoreg_M && mh_rt;
      lw = memtoreg_E && regwrite_E && (eh_rs || eh_rt);
      br = (branch_D && regwrite_E && (eh_rs || eh_rt)) || (jr_D && regwrite_E && eh_rs)
        || (branch_D && memtoreg_M && (mh_rs || mh_rt)) || (jr_D && memtoreg_M && mh_rs);
      md = md_use_D && (m_busy || md_start_E);
      e_st = lw || br || md;
      cmp("m_fwd_AE", fwd_AE, e_ae);
      cmp("m_fwd_BE", fwd_BE, e_be);
      cmp("m_fwd_AD", fwd_AD, e_ad);
      cmp("m_fwd_BD", fwd_BD, e_bd);
      cmp("m_stall_F", stall_F, e_st);
      cmp("m_stall_D", stall_D, e_st);
      cmp("m_flush_E", flush_E, e_st);
      cmp("m_md_busy", md_busy, m_busy);
    end
  end

  task automatic clear_in();
    rs_D = '0; rt_D = '0; rs_E = '0; rt_E = '0;
    writereg_E = '0; writereg_M = '0; writereg_W = '0;
    use_rs_D = 0; use_rt_D = 0; branch_D = 0; jr_D = 0; md_use_D = 0;
    regwrite_E = 0; memtoreg_E = 0; md_start_E = 0; md_div_E = 0;
    regwrite_M = 0; memtoreg_M = 0; regwrite_W = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
    #1;
  endtask

  task automatic md_run(input bit is_div, input int exp_cycles, input string name);
    int n;
    clear_in();
    md_start_E = 1; md_div_E = is_div; md_use_D = 1;
    sample();
    cmp({name, "_first"}, stall_F, 1);
    tick();
    md_start_E = 0; md_div_E = 0;
    n = 1;
    for (int i = 0; i < 30; i++) begin
      sample();
      if (!stall_F) break;
      n++;
      tick();
    end
    cmp(name, n, exp_cycles);
    tick();
  endtask

  initial begin
    rst_n = 0;
    clear_in();
    chk_en = 1;
    sample();
    cmp("reset_busy", md_busy, 0);
    cmp("reset_stall", stall_F, 0);
    tick(); tick();
    rst_n = 1;
    tick();

    // forwarding priority
    rs_E = 3; rt_E = 3; regwrite_M = 1; writereg_M = 3; regwrite_W = 1; writereg_W = 3;
    sample();
    cmp("fwd_AE_M", fwd_AE, 2);
    cmp("fwd_BE_M", fwd_BE, 2);
    tick();
    writereg_M = 4;
    sample();
    cmp("fwd_AE_W", fwd_AE, 1);
    tick();

    // load-use
    clear_in();
    memtoreg_E = 1; regwrite_E = 1; writereg_E = 8; rt_D = 8; use_rt_D = 1;
    sample();
    cmp("lw_stall", stall_F, 1);
    cmp("lw_flush", flush_E, 1);
    tick();
    memtoreg_E = 0; regwrite_E = 0; writereg_E = 0;
    memtoreg_M = 1; regwrite_M = 1; writereg_M = 8;
    sample();
    cmp("lw_release", stall_D, 0);
    tick();
    clear_in();
    memtoreg_E = 1; regwrite_E = 1; writereg_E = 0; rt_D = 0; use_rt_D = 1;
    sample();
    cmp("lw_r0", stall_F, 0);
    tick();

    // branch after load: two stall cycles
    clear_in();
    branch_D = 1; use_rs_D = 1; rs_D = 5;
    memtoreg_E = 1; regwrite_E = 1; writereg_E = 5;
    sample();
    cmp("br_ld_1", stall_F, 1);
    tick();
    memtoreg_E = 0; regwrite_E = 0; writereg_E = 0;
    memtoreg_M = 1; regwrite_M = 1; writereg_M = 5;
    sample();
    cmp("br_ld_2", stall_F, 1);
    cmp("br_ld_nofwd", fwd_AD, 0);
    tick();
    memtoreg_M = 0; regwrite_M = 0; writereg_M = 0; regwrite_W = 1; writereg_W = 5;
    sample();
    cmp("br_ld_3", stall_F, 0);
    tick();

    // branch after ALU: one stall then forward
    clear_in();
    branch_D = 1; use_rs_D = 1; rs_D = 5; regwrite_E = 1; writereg_E = 5;
    sample();
    cmp("br_alu_1", stall_F, 1);
    tick();
    regwrite_E = 0; writereg_E = 0; regwrite_M = 1; writereg_M = 5;
    sample();
    cmp("br_alu_2", stall_F, 0);
    cmp("br_alu_fwd", fwd_AD, 1);
    tick();

    md_run(0, MUL + 1, "mul_stall_cycles");
    md_run(1, DIV + 1, "div_stall_cycles");

    // reset during a div
    clear_in();
    md_start_E = 1; md_div_E = 1;
    tick();
    md_start_E = 0; md_div_E = 0;
    tick(); tick();
    rst_n = 0; md_use_D = 1;
    sample();
    cmp("rst_busy", md_busy, 0);
    cmp("rst_stall", stall_F, 0);
    tick();
    rst_n = 1;
    sample();
    cmp("rst_mflo", stall_F, 0);
    tick();

    // all-zero registers with every write asserted
    clear_in();
    use_rs_D = 1; use_rt_D = 1; branch_D = 1; jr_D = 1;
    regwrite_E = 1; memtoreg_E = 1; regwrite_M = 1; memtoreg_M = 1; regwrite_W = 1;
    sample();
    cmp("r0_fwdAE", fwd_AE, 0);
    cmp("r0_fwdBE", fwd_BE, 0);
    cmp("r0_fwdAD", fwd_AD, 0);
    cmp("r0_stall", stall_F, 0);
    tick();

    // randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      rs_D = AW'($urandom_range(0, 3)); rt_D = AW'($urandom_range(0, 3));
      rs_E = AW'($urandom_range(0, 3)); rt_E = AW'($urandom_range(0, 3));
      writereg_E = AW'($urandom_range(0, 3));
      writereg_M = AW'($urandom_range(0, 3));
      writereg_W = AW'($urandom_range(0, 3));
      use_rs_D = 1'($urandom); use_rt_D = 1'($urandom);
      branch_D = ($urandom_range(0, 3) == 0); jr_D = ($urandom_range(0, 5) == 0);
      md_use_D = ($urandom_range(0, 2) == 0);
      regwrite_E = 1'($urandom); memtoreg_E = 1'($urandom);
      md_start_E = ($urandom_range(0, 9) == 0); md_div_E = 1'($urandom);
      regwrite_M = 1'($urandom); memtoreg_M = 1'($urandom);
      regwrite_W = 1'($urandom);
      rst_n = ($urandom_range(0, 149) != 0);
      tick();
    end
    rst_n = 1;
    clear_in();
    tick();

    chk_en = 0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
